// File: rtl/pipeline_redirect_ctrl_pkg.sv
// Shared encodings for the redirect controller and the PC update register:
// PCSrc codes, controller FSM states and exception vector addresses.
package pipeline_redirect_ctrl_pkg;

  localparam logic [2:0] PCSRC_SEQ   = 3'b000;
  localparam logic [2:0] PCSRC_BR    = 3'b001;
  localparam logic [2:0] PCSRC_J     = 3'b010;
  localparam logic [2:0] PCSRC_JR    = 3'b011;
  localparam logic [2:0] PCSRC_ILLOP = 3'b100;
  localparam logic [2:0] PCSRC_XADR  = 3'b101;

  localparam logic [31:0] ILLOP_ADDR = 32'h8000_0004;
  localparam logic [31:0] XADR_ADDR  = 32'h8000_0008;

  typedef enum logic [1:0] {
    ST_RUN      = 2'b00,
    ST_IRQ_WAIT = 2'b01,
    ST_SHADOW   = 2'b10
  } redirect_state_e;

endpackage

// File: rtl/pipeline_redirect_ctrl_hazard_detect.sv
// Load-use hazard compare: a load in EX whose destination feeds the
// instruction in ID. Register 0 never creates a dependency.
module pipeline_hazard_detect #(
  parameter int REG_W = 5
) (
  input  logic             ex_memread_i,
  input  logic [REG_W-1:0] ex_rt_i,
  input  logic [REG_W-1:0] id_rs_i,
  input  logic [REG_W-1:0] id_rt_i,
  input  logic             id_uses_rt_i,
  output logic             load_use_o
);

  assign load_use_o = ex_memread_i
                    & (ex_rt_i != {REG_W{1'b0}})
                    & ((ex_rt_i == id_rs_i) | (id_uses_rt_i & (ex_rt_i == id_rt_i)));

endmodule

// File: rtl/pipeline_redirect_ctrl.sv
// Pipeline redirect controller: arbitrates branch/exception/interrupt/stall/jump
// redirects and owns EPC plus the interrupt shadow. Option macro: IRQ_LATCH_EN.
module pipeline_redirect_ctrl
  import pipeline_redirect_ctrl_pkg::*;
#(
  parameter int SHADOW_CYCLES = 2,
  parameter int REG_W         = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             irq,
  input  logic             pc_kernel,
  input  logic [31:0]      id_pc,
  input  logic             id_illegal,
  input  logic             id_jump,
  input  logic             id_jr,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rt,
  input  logic             ex_memread,
  input  logic [REG_W-1:0] ex_rt,
  input  logic             ex_branch,
  input  logic             ex_branch_taken,
  output logic [2:0]       PCSrc,
  output logic             PCWrite,
  output logic             IF_ID_write,
  output logic             IF_ID_flush,
  output logic             ID_EX_flush,
  output logic [31:0]      epc,
  output logic             irq_ack
);

  localparam int CNT_W = $clog2(SHADOW_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SHADOW_CYCLES - 1);

  redirect_state_e  state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      epc_q, epc_d;
  logic             irq_ack_q, irq_ack_d;

  logic             load_use_s;
  logic             irq_src_s;
  logic             irq_ok_s;
  logic             take_illop_s;
  logic             take_irq_s;
  logic [2:0]       pcsrc_s;
  logic             pcwrite_s;
  logic             ifid_write_s;
  logic             ifid_flush_s;
  logic             idex_flush_s;

  pipeline_hazard_detect #(
    .REG_W (REG_W)
  ) u_hazard (
    .ex_memread_i (ex_memread),
    .ex_rt_i      (ex_rt),
    .id_rs_i      (id_rs),
    .id_rt_i      (id_rt),
    .id_uses_rt_i (id_uses_rt),
    .load_use_o   (load_use_s)
  );

`ifdef IRQ_LATCH_EN
  logic irq_prev_q;
  logic irq_pend_q, irq_pend_d;

  // Sticky pending flag: set on a rising irq edge, cleared when the interrupt is taken.
  always_comb begin
    irq_pend_d = (irq_pend_q & ~take_irq_s) | (irq & ~irq_prev_q);
  end

  // Edge-detect history and pending flag registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      irq_prev_q <= 1'b0;
      irq_pend_q <= 1'b0;
    end else begin
      irq_prev_q <= irq;
      irq_pend_q <= irq_pend_d;
    end
  end

  assign irq_src_s = irq_pend_q;
`else
  assign irq_src_s = irq;
`endif

  assign irq_ok_s = irq_src_s & ~pc_kernel & ~ex_branch & (state_q != ST_SHADOW);

  // Strict-priority redirect arbitration; reset forces the sequential-fetch defaults.
  always_comb begin
    pcsrc_s      = PCSRC_SEQ;
    pcwrite_s    = 1'b1;
    ifid_write_s = 1'b1;
    ifid_flush_s = 1'b0;
    idex_flush_s = 1'b0;
    take_illop_s = 1'b0;
    take_irq_s   = 1'b0;
    if (!reset) begin
      pcsrc_s = PCSRC_SEQ;
    end else if (ex_branch & ex_branch_taken) begin
      pcsrc_s      = PCSRC_BR;
      ifid_flush_s = 1'b1;
      idex_flush_s = 1'b1;
    end else if (id_illegal) begin
      pcsrc_s      = PCSRC_ILLOP;
      ifid_flush_s = 1'b1;
      idex_flush_s = 1'b1;
      take_illop_s = 1'b1;
    end else if (irq_ok_s) begin
      pcsrc_s      = PCSRC_XADR;
      ifid_flush_s = 1'b1;
      idex_flush_s = 1'b1;
      take_irq_s   = 1'b1;
    end else if (load_use_s) begin
      pcwrite_s    = 1'b0;
      ifid_write_s = 1'b0;
      idex_flush_s = 1'b1;
    end else if (id_jr) begin
      pcsrc_s      = PCSRC_JR;
      ifid_flush_s = 1'b1;
    end else if (id_jump) begin
      pcsrc_s      = PCSRC_J;
      ifid_flush_s = 1'b1;
    end else if (ex_branch) begin
      // Untaken branch: the PC register falls back to PC+4 on its own.
      pcsrc_s = PCSRC_BR;
    end else begin
      pcsrc_s = PCSRC_SEQ;
    end
  end

  // Next-state, shadow counter, EPC and acknowledge computation.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    epc_d     = epc_q;
    irq_ack_d = take_irq_s;
    if (take_illop_s) begin
      epc_d   = id_pc + 32'd4;
      state_d = ST_SHADOW;
      cnt_d   = CNT_LOAD;
    end else if (take_irq_s) begin
      epc_d   = id_pc;
      state_d = ST_SHADOW;
      cnt_d   = CNT_LOAD;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (irq_src_s & ~pc_kernel & ex_branch) begin
            state_d = ST_IRQ_WAIT;
          end else begin
            state_d = ST_RUN;
          end
        end
        ST_IRQ_WAIT: begin
          if (!irq_src_s) begin
            state_d = ST_RUN;
          end else begin
            state_d = ST_IRQ_WAIT;
          end
        end
        ST_SHADOW: begin
          if (cnt_q == {CNT_W{1'b0}}) begin
            state_d = ST_RUN;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        default: begin
          state_d = ST_RUN;
          cnt_d   = {CNT_W{1'b0}};
        end
      endcase
    end
  end

  // State, counter, EPC and acknowledge registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_RUN;
      cnt_q     <= {CNT_W{1'b0}};
      epc_q     <= 32'h0000_0000;
      irq_ack_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      epc_q     <= epc_d;
      irq_ack_q <= irq_ack_d;
    end
  end

  assign PCSrc       = pcsrc_s;
  assign PCWrite     = pcwrite_s;
  assign IF_ID_write = ifid_write_s;
  assign IF_ID_flush = ifid_flush_s;
  assign ID_EX_flush = idex_flush_s;
  assign epc         = epc_q;
  assign irq_ack     = irq_ack_q;

endmodule
